// File: rtl/multicycle_cpu.sv
// Multicycle RV32I core: FETCH -> EXEC (-> MEM) -> FETCH, one architectural
// instruction at a time over separate instruction and data request ports.
module multicycle_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] iaddr,
    output logic        ireq,
    input  logic        iready,
    input  logic [31:0] idata,
    output logic [31:0] daddr,
    output logic        dreq,
    input  logic        dready,
    input  logic [31:0] drdata,
    output logic [31:0] dwdata,
    output logic [3:0]  mem_we,
    output logic [31:0] pc,
    output logic [31:0] x31,
    output logic        retire,
    output logic        illegal
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] MEM   = 2'd2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] dwdata_q, dwdata_d;
    logic [3:0]  mem_we_q, mem_we_d;
    logic        retire_q, retire_d;
    logic        illegal_q, illegal_d;
    logic        run_q;
    logic [31:0] regs_q [32];

    logic        rf_we;
    logic [31:0] rf_wdata;

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd_a, rs1_a, rs2_a;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_v, rs2_v, pc_plus4;

    function automatic logic idx_ok(input logic [4:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    assign opcode = ir_q[6:0];
    assign rd_a   = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1_a  = ir_q[19:15];
    assign rs2_a  = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // x0 is never written, so it reads zero without a special case here
    assign rs1_v    = idx_ok(rs1_a) ? regs_q[rs1_a] : '0;
    assign rs2_v    = idx_ok(rs2_a) ? regs_q[rs2_a] : '0;
    assign pc_plus4 = pc_q + 32'd4;

    logic [31:0] alu_b, alu_res;
    logic        alu_ok;

    always_comb begin
        alu_b   = (opcode == OP_OP) ? rs2_v : imm_i;
        alu_res = '0;
        case (funct3)
            3'b000: alu_res = (opcode == OP_OP && funct7[5]) ? rs1_v - alu_b : rs1_v + alu_b;
            3'b001: alu_res = rs1_v << alu_b[4:0];
            3'b010: alu_res = {31'b0, $signed(rs1_v) < $signed(alu_b)};
            3'b011: alu_res = {31'b0, rs1_v < alu_b};
            3'b100: alu_res = rs1_v ^ alu_b;
            3'b101: alu_res = funct7[5] ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
            3'b110: alu_res = rs1_v | alu_b;
            default: alu_res = rs1_v & alu_b;
        endcase
        if (opcode == OP_OP)
            alu_ok = (funct7 == 7'h00) || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
        else if (funct3 == 3'b001)
            alu_ok = (funct7 == 7'h00);
        else if (funct3 == 3'b101)
            alu_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
        else
            alu_ok = 1'b1;
    end

    logic        ex_ill, ex_we, ex_mem, ex_load, use_rs1, use_rs2, taken;
    logic [31:0] ex_wd, ex_npc, ex_addr, ex_st_data;
    logic [3:0]  ex_st_we;

    always_comb begin
        ex_ill     = 1'b0;
        ex_we      = 1'b0;
        ex_mem     = 1'b0;
        ex_load    = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        taken      = 1'b0;
        ex_wd      = '0;
        ex_npc     = pc_plus4;
        ex_addr    = rs1_v + imm_i;
        ex_st_data = '0;
        ex_st_we   = '0;
        case (opcode)
            OP_LUI:   begin ex_we = 1'b1; ex_wd = imm_u; end
            OP_AUIPC: begin ex_we = 1'b1; ex_wd = pc_q + imm_u; end
            OP_JAL: begin
                ex_we  = 1'b1;
                ex_wd  = pc_plus4;
                ex_npc = (pc_q + imm_j) & ~32'd3;
            end
            OP_JALR: begin
                use_rs1 = 1'b1;
                ex_ill  = (funct3 != 3'b000);
                ex_we   = 1'b1;
                ex_wd   = pc_plus4;
                ex_npc  = (rs1_v + imm_i) & ~32'd3;
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                case (funct3)
                    3'b000: taken = (rs1_v == rs2_v);
                    3'b001: taken = (rs1_v != rs2_v);
                    3'b100: taken = ($signed(rs1_v) < $signed(rs2_v));
                    3'b101: taken = ($signed(rs1_v) >= $signed(rs2_v));
                    3'b110: taken = (rs1_v < rs2_v);
                    3'b111: taken = (rs1_v >= rs2_v);
                    default: ex_ill = 1'b1;
                endcase
                if (taken) ex_npc = (pc_q + imm_b) & ~32'd3;
            end
            OP_LOAD: begin
                use_rs1 = 1'b1;
                ex_load = 1'b1;
                ex_ill  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
                ex_mem  = 1'b1;
            end
            OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                ex_addr = rs1_v + imm_s;
                ex_mem  = 1'b1;
                case (funct3)
                    3'b000: begin
                        ex_st_we   = 4'b0001 << ex_addr[1:0];
                        ex_st_data = {4{rs2_v[7:0]}};
                    end
                    3'b001: begin
                        ex_st_we   = 4'b0011 << {ex_addr[1], 1'b0};
                        ex_st_data = {2{rs2_v[15:0]}};
                    end
                    3'b010: begin
                        ex_st_we   = 4'b1111;
                        ex_st_data = rs2_v;
                    end
                    default: ex_ill = 1'b1;
                endcase
            end
            OP_IMM, OP_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = (opcode == OP_OP);
                ex_ill  = !alu_ok;
                ex_we   = 1'b1;
                ex_wd   = alu_res;
            end
            OP_FENCE, OP_SYSTEM: ex_ill = (funct3 != 3'b000);
            default: ex_ill = 1'b1;
        endcase
        if ((use_rs1 && !idx_ok(rs1_a)) || (use_rs2 && !idx_ok(rs2_a)) ||
            ((ex_we || ex_load) && !idx_ok(rd_a)))
            ex_ill = 1'b1;
        if (ex_ill) begin
            ex_we  = 1'b0;
            ex_mem = 1'b0;
            ex_npc = pc_plus4;
        end
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        case (daddr_q[1:0])
            2'd0:    ld_byte = drdata[7:0];
            2'd1:    ld_byte = drdata[15:8];
            2'd2:    ld_byte = drdata[23:16];
            default: ld_byte = drdata[31:24];
        endcase
        ld_half = daddr_q[1] ? drdata[31:16] : drdata[15:0];
        case (funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'b0, ld_byte};
            3'b101:  ld_data = {16'b0, ld_half};
            default: ld_data = drdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        daddr_d   = daddr_q;
        dwdata_d  = dwdata_q;
        mem_we_d  = mem_we_q;
        retire_d  = 1'b0;
        illegal_d = 1'b0;
        rf_we     = 1'b0;
        rf_wdata  = ex_wd;
        case (state_q)
            FETCH: if (run_q && iready) begin
                ir_d    = idata;
                state_d = EXEC;
            end
            EXEC: if (ex_mem) begin
                daddr_d  = ex_addr;
                dwdata_d = ex_st_data;
                mem_we_d = ex_st_we;
                state_d  = MEM;
            end else begin
                rf_we     = ex_we;
                pc_d      = ex_npc;
                retire_d  = 1'b1;
                illegal_d = ex_ill;
                state_d   = FETCH;
            end
            MEM: if (dready) begin
                rf_we    = (opcode == OP_LOAD);
                rf_wdata = ld_data;
                pc_d     = pc_plus4;
                mem_we_d = '0;
                retire_d = 1'b1;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // run_q holds off fetch until the first clock edge after reset release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            daddr_q   <= '0;
            dwdata_q  <= '0;
            mem_we_q  <= '0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            run_q     <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            daddr_q   <= daddr_d;
            dwdata_q  <= dwdata_d;
            mem_we_q  <= mem_we_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
            run_q     <= 1'b1;
            if (rf_we && rd_a != 5'd0 && idx_ok(rd_a)) regs_q[rd_a] <= rf_wdata;
        end
    end

    assign iaddr   = pc_q;
    assign pc      = pc_q;
    assign ireq    = (state_q == FETCH) && run_q;
    assign dreq    = (state_q == MEM);
    assign daddr   = daddr_q;
    assign dwdata  = dwdata_q;
    assign mem_we  = (state_q == MEM) ? mem_we_q : '0;
    assign x31     = regs_q[31];
    assign retire  = retire_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: a straight-line program table plus
// hand sequences for delayed stores, retire pulse width and reset mid-access.
module tb_multicycle_cpu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] iaddr, daddr, drdata, dwdata, pc, x31, idata;
    logic        ireq, iready, dreq, dready, retire, illegal;
    logic [3:0]  mem_we;

    logic [31:0] iaddr16, daddr16, dwdata16, pc16, x31_16;
    logic        ireq16, dreq16, retire16, illegal16;
    logic [3:0]  mem_we16;
    logic        iready16 = 1'b1;
    logic        dready16 = 1'b0;
    logic [31:0] idata16  = 32'h00500F93;
    logic [31:0] drdata16 = 32'h0;

    always #5 clk = ~clk;

    multicycle_cpu #(.RESET_PC(32'h100), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .iaddr(iaddr), .ireq(ireq), .iready(iready), .idata(idata),
        .daddr(daddr), .dreq(dreq), .dready(dready), .drdata(drdata), .dwdata(dwdata),
        .mem_we(mem_we), .pc(pc), .x31(x31), .retire(retire), .illegal(illegal)
    );

    multicycle_cpu #(.RESET_PC(32'h100), .NUM_REGS(16)) dut16 (
        .clk(clk), .reset(reset), .iaddr(iaddr16), .ireq(ireq16), .iready(iready16), .idata(idata16),
        .daddr(daddr16), .dreq(dreq16), .dready(dready16), .drdata(drdata16), .dwdata(dwdata16),
        .mem_we(mem_we16), .pc(pc16), .x31(x31_16), .retire(retire16), .illegal(illegal16)
    );

    int checks = 0;
    int failures = 0;
    logic ireq_leak = 1'b0;
    logic we_leak = 1'b0;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_we;
    logic        m_unstable;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one instruction at a negedge and follow it to retirement (bounded).
    task automatic run(input logic [31:0] instr, input logic [31:0] rdata, input int dwait,
                       output int cyc, output int mcyc, output logic ill, output logic ok);
        cyc = 0; mcyc = 0; ill = 1'b0; ok = 1'b0; m_unstable = 1'b0;
        m_addr = '0; m_wd = '0; m_we = '0;
        iready = 1'b1; idata = instr;
        @(negedge clk); cyc = 1;
        iready = 1'b0; idata = '0;
        while (!ok && cyc < 40) begin
            if (ireq) ireq_leak = 1'b1;
            if (dreq) begin
                if (mcyc == 0) begin
                    m_addr = daddr; m_we = mem_we; m_wd = dwdata;
                end else if (daddr !== m_addr || mem_we !== m_we || dwdata !== m_wd) begin
                    m_unstable = 1'b1;
                end
                mcyc++;
                dready = (mcyc > dwait);
                drdata = rdata;
            end else begin
                dready = 1'b0;
                if (mem_we !== 4'b0) we_leak = 1'b1;
            end
            @(negedge clk); cyc++;
            if (retire) begin ok = 1'b1; ill = illegal; end
        end
        dready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rdata;
        logic [31:0] exp_pc;
        logic [31:0] exp_x31;
        logic        exp_ill;
        int          exp_cyc;
    } vec_t;

    vec_t tbl [29];

    initial begin
        int   cyc, mcyc;
        logic ill, ok;
        bit   seen;

        tbl[0]  = '{32'h00500F93, 32'h0,        32'h104,      32'h5,        1'b0, 2};
        tbl[1]  = '{32'hFF9F8F93, 32'h0,        32'h108,      32'hFFFFFFFE, 1'b0, 2};
        tbl[2]  = '{32'h000010B7, 32'h0,        32'h10C,      32'hFFFFFFFE, 1'b0, 2};
        tbl[3]  = '{32'h00308093, 32'h0,        32'h110,      32'hFFFFFFFE, 1'b0, 2};
        tbl[4]  = '{32'h0AB00113, 32'h0,        32'h114,      32'hFFFFFFFE, 1'b0, 2};
        tbl[5]  = '{32'h00201F83, 32'h80FF0000, 32'h118,      32'hFFFF80FF, 1'b0, 3};
        tbl[6]  = '{32'h00205F83, 32'h80FF0000, 32'h11C,      32'h000080FF, 1'b0, 3};
        tbl[7]  = '{32'h00300F83, 32'h80FF0000, 32'h120,      32'hFFFFFF80, 1'b0, 3};
        tbl[8]  = '{32'h00104F83, 32'h12345678, 32'h124,      32'h00000056, 1'b0, 3};
        tbl[9]  = '{32'h00302F83, 32'hDEADBEEF, 32'h128,      32'hDEADBEEF, 1'b0, 3};
        tbl[10] = '{32'h00301F83, 32'h80FF1234, 32'h12C,      32'hFFFF80FF, 1'b0, 3};
        tbl[11] = '{32'h40208FB3, 32'h0,        32'h130,      32'h00000F58, 1'b0, 2};
        tbl[12] = '{32'h80000FB7, 32'h0,        32'h134,      32'h80000000, 1'b0, 2};
        tbl[13] = '{32'h404FDF93, 32'h0,        32'h138,      32'hF8000000, 1'b0, 2};
        tbl[14] = '{32'h01CFDF93, 32'h0,        32'h13C,      32'h0000000F, 1'b0, 2};
        tbl[15] = '{32'h00103F93, 32'h0,        32'h140,      32'h00000001, 1'b0, 2};
        tbl[16] = '{32'h01F11FB3, 32'h0,        32'h144,      32'h00000156, 1'b0, 2};
        tbl[17] = '{32'hFFF04F93, 32'h0,        32'h148,      32'hFFFFFFFF, 1'b0, 2};
        tbl[18] = '{32'h002FAFB3, 32'h0,        32'h14C,      32'h00000001, 1'b0, 2};
        tbl[19] = '{32'h00001F97, 32'h0,        32'h150,      32'h0000114C, 1'b0, 2};
        tbl[20] = '{32'h00000073, 32'h0,        32'h154,      32'h0000114C, 1'b0, 2};
        tbl[21] = '{32'h0000000F, 32'h0,        32'h158,      32'h0000114C, 1'b0, 2};
        tbl[22] = '{32'hFFFFFFFF, 32'h0,        32'h15C,      32'h0000114C, 1'b1, 2};
        tbl[23] = '{32'h40006FB3, 32'h0,        32'h160,      32'h0000114C, 1'b1, 2};
        tbl[24] = '{32'h02000067, 32'h0,        32'h020,      32'h0000114C, 1'b0, 2};
        tbl[25] = '{32'h00700FE7, 32'h0,        32'h004,      32'h00000024, 1'b0, 2};
        tbl[26] = '{32'hFE000CE3, 32'h0,        32'hFFFFFFFC, 32'h00000024, 1'b0, 2};
        tbl[27] = '{32'hFE001CE3, 32'h0,        32'h000,      32'h00000024, 1'b0, 2};
        tbl[28] = '{32'h00800FEF, 32'h0,        32'h008,      32'h00000004, 1'b0, 2};

        reset = 1'b1; iready = 1'b0; idata = '0; dready = 1'b0; drdata = '0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 32'h100);
        check("rst_iaddr", iaddr, 32'h100);
        check("rst_ireq", 32'(ireq), 32'h0);
        check("rst_x31", x31, 32'h0);
        check("rst_outs", {28'b0, retire, illegal, dreq, |mem_we}, 32'h0);
        reset = 1'b0;
        #1 check("ireq_before_edge", 32'(ireq), 32'h0);
        @(negedge clk);
        check("ireq_after_edge", 32'(ireq), 32'h1);
        check("iaddr_after_edge", iaddr, 32'h100);

        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (retire16) seen = 1'b1;
        end
        check("rv32e_retire", 32'(seen), 32'h1);
        check("rv32e_illegal", 32'(illegal16), 32'h1);
        check("rv32e_pc", pc16, 32'h104);
        check("rv32e_x31", x31_16, 32'h0);

        for (int i = 0; i < 29; i++) begin
            run(tbl[i].instr, tbl[i].rdata, 0, cyc, mcyc, ill, ok);
            check($sformatf("v%0d_retire", i), 32'(ok), 32'h1);
            check($sformatf("v%0d_pc", i), pc, tbl[i].exp_pc);
            check($sformatf("v%0d_x31", i), x31, tbl[i].exp_x31);
            check($sformatf("v%0d_illegal", i), 32'(ill), 32'(tbl[i].exp_ill));
            check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(tbl[i].exp_cyc));
        end

        // SB x2,0(x1) with dready three cycles late
        run(32'h00208023, 32'h0, 3, cyc, mcyc, ill, ok);
        check("sb_retire", 32'(ok), 32'h1);
        check("sb_daddr", m_addr, 32'h1003);
        check("sb_we", 32'(m_we), 32'h8);
        check("sb_wdata", m_wd, 32'hABABABAB);
        check("sb_stable", 32'(m_unstable), 32'h0);
        check("sb_dreq_cycles", 32'(mcyc), 32'h4);
        check("sb_cycles", 32'(cyc), 32'h6);
        check("sb_pc", pc, 32'h00C);
        @(negedge clk);
        check("retire_one_cycle", 32'(retire), 32'h0);

        run(32'h002091A3, 32'h0, 0, cyc, mcyc, ill, ok);
        check("sh_daddr", m_addr, 32'h1006);
        check("sh_we", 32'(m_we), 32'hC);
        check("sh_wdata", m_wd, 32'h00AB00AB);
        check("sh_pc", pc, 32'h010);

        run(32'h00102023, 32'h0, 0, cyc, mcyc, ill, ok);
        check("sw_daddr", m_addr, 32'h0);
        check("sw_we", 32'(m_we), 32'hF);
        check("sw_wdata", m_wd, 32'h00001003);
        check("sw_pc", pc, 32'h014);

        // SW issued, reset hits while the access is pending
        iready = 1'b1; idata = 32'h00102023;
        @(negedge clk);
        iready = 1'b0; idata = '0;
        @(negedge clk);
        check("mid_dreq", 32'(dreq), 32'h1);
        check("mid_we", 32'(mem_we), 32'hF);
        #2 reset = 1'b1;
        #1;
        check("rstmem_dreq", 32'(dreq), 32'h0);
        check("rstmem_we", 32'(mem_we), 32'h0);
        check("rstmem_ireq", 32'(ireq), 32'h0);
        dready = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (retire) seen = 1'b1;
        end
        check("rstmem_no_retire", 32'(seen), 32'h0);
        dready = 1'b0;
        reset = 1'b0;
        check("rstmem_pc", pc, 32'h100);
        check("rstmem_x31", x31, 32'h0);
        @(negedge clk);
        run(32'h00500F93, 32'h0, 0, cyc, mcyc, ill, ok);
        check("recover_pc", pc, 32'h104);
        check("recover_x31", x31, 32'h5);

        check("ireq_outside_fetch", 32'(ireq_leak), 32'h0);
        check("we_outside_mem", 32'(we_leak), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 SHALL have parameter NUM_REGS, default 32: architectural register count, legal values 16 (RV32E) or 32.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port iaddr  output  32: instruction address, equal to pc.
REQ-006 SHALL have port ireq  output  1: instruction fetch request.
REQ-007 SHALL have port iready  input  1: idata valid this cycle.
REQ-008 SHALL have port idata  input  32: instruction word.
REQ-009 SHALL have port daddr  output  32: data address (rs1 + imm).
REQ-010 SHALL have port dreq  output  1: data access request.
REQ-011 SHALL have port dready  input  1: data access completes this cycle.
REQ-012 SHALL have port drdata  input  32: read data.
REQ-013 SHALL have port dwdata  output  32: write data.
REQ-014 SHALL have port mem_we  output  4: per-byte write enable.
REQ-015 SHALL have port pc  output  32: current PC.
REQ-016 SHALL have port x31  output  32: register x31 (zero when NUM_REGS=16).
REQ-017 SHALL have port retire  output  1: one-cycle pulse when an instruction completes.
REQ-018 SHALL have port illegal  output  1: one-cycle pulse with retire for an undecodable instruction.

Function
REQ-019 SHALL implement RV32I base integer instructions (LUI, AUIPC, JAL, JALR, branches, loads, stores, OP-IMM, OP); FENCE/ECALL/EBREAK SHALL retire as NOP.
REQ-020 SHALL use FSM states FETCH, EXEC, MEM; reset state FETCH.
REQ-021 FETCH: ireq=1; on iready latch idata into instruction register, go to EXEC; otherwise stay, pc stable.
REQ-022 EXEC, non-memory instruction: write rd, update pc, pulse retire, go to FETCH (CPI 2 with zero-wait memory).
REQ-023 EXEC, load/store: register daddr, dwdata, mem_we, go to MEM.
REQ-024 MEM: dreq=1, daddr/dwdata/mem_we held stable until dready; on dready: load writes rd, pc=pc+4, retire pulses, go to FETCH (CPI 3 minimum).
REQ-025 dreq and mem_we SHALL be 0 outside MEM; ireq SHALL be 0 outside FETCH.
REQ-026 Store lanes: SB mem_we=4'b0001<<daddr[1:0], dwdata=rs2[7:0] replicated x4; SH mem_we=4'b0011<<{daddr[1],1'b0}, dwdata=rs2[15:0] replicated x2; SW mem_we=4'b1111.
REQ-027 Loads SHALL select byte/halfword by daddr[1:0] and sign-extend (LB, LH) or zero-extend (LBU, LHU).
REQ-028 Misaligned halfword/word access SHALL use daddr[1:0] forced to aligned lane (daddr[0] ignored for H, daddr[1:0] ignored for W) with no trap.
REQ-029 Branch taken: pc=pc+imm; JAL: pc=pc+imm; JALR: pc=(rs1+imm); all targets SHALL have bits [1:0] forced to 0; JAL/JALR write rd=old pc+4.
REQ-030 All arithmetic 32-bit modulo 2^32; shifts use shamt [4:0]; SLT/SLTU signed/unsigned.
REQ-031 x0 SHALL read 0 and ignore writes; register index >= NUM_REGS SHALL read 0, write ignored, and raise illegal.
REQ-032 Unknown opcode/funct SHALL retire with illegal=1, no register/memory write, pc=pc+4.
REQ-033 rd==rs1 in same instruction SHALL use the pre-write rs1 value.

Reset
REQ-034 Reset SHALL asynchronously force: state FETCH, pc=RESET_PC, all registers 0, retire=0, illegal=0, dreq=0, mem_we=0.
REQ-035 Reset asserted during MEM SHALL drop dreq/mem_we immediately; the pending access SHALL not retire.
REQ-036 ireq SHALL be 0 while reset is high and assert on the first clk edge after release.

Verification
REQ-037 Reset with RESET_PC=32'h100 -> iaddr=32'h100, ireq=1 after release, x31=0.
REQ-038 ADDI x31,x0,5 then ADDI x31,x31,-7, iready tied 1 -> x31=32'hFFFFFFFE after 4 cycles, two retire pulses.
REQ-039 x1=32'h1003, SB x2=32'hAB to 0(x1), dready delayed 3 cycles -> mem_we=4'b1000, dwdata=32'hABABABAB held 4 cycles, retire on dready.
REQ-040 drdata=32'h80FF0000, LH from addr 2 -> rd=32'hFFFF80FF; LHU -> 32'h000080FF.
REQ-041 JALR x31,7(x0) at pc=32'h20 -> pc=32'h4, x31=32'h24; BEQ x0,x0,-8 -> pc-8.
REQ-042 Word 32'hFFFFFFFF fetched -> illegal and retire pulse together, pc+4, no write; reset mid-MEM -> dreq=0 same cycle.
